// File: rtl/masked_random_feeder.sv
// Fresh-randomness source for the masked HPC1 multiplier harness: parallel 32-bit
// Fibonacci LFSRs, seeded word by word, warmed up, then stepped once per consumed vector.

package masked_random_feeder_pkg;

    // Raw zero-sharing words needed by masked_zero for n shares.
    function automatic int num_zero_random(input int n);
        return (n * (n - 1)) / 2;
    endfunction

    // HPC1 p words: one per unordered share pair.
    function automatic int num_quad(input int n);
        return (n * (n - 1)) / 2;
    endfunction

endpackage

module masked_random_feeder #(
    parameter int NUM_SHARES    = 2,
    parameter int BIT_WIDTH     = 4,
    parameter int WARMUP_CYCLES = 16
) (
    input  logic        in_clock,
    input  logic        in_reset,
    input  logic [31:0] in_seed,
    input  logic        in_seed_valid,
    output logic        out_seed_ready,
    output logic [masked_random_feeder_pkg::num_zero_random(NUM_SHARES)*BIT_WIDTH-1:0] out_r_raw,
    output logic [masked_random_feeder_pkg::num_quad(NUM_SHARES)*BIT_WIDTH-1:0]        out_p,
    output logic        out_valid,
    input  logic        in_ready
);

    localparam int R_BITS   = masked_random_feeder_pkg::num_zero_random(NUM_SHARES) * BIT_WIDTH;
    localparam int P_BITS   = masked_random_feeder_pkg::num_quad(NUM_SHARES) * BIT_WIDTH;
    localparam int OUT_BITS = R_BITS + P_BITS;
    localparam int NUM_LFSR = (OUT_BITS + 31) / 32;
    localparam int IDX_W    = (NUM_LFSR < 2) ? 1 : $clog2(NUM_LFSR + 1);

    localparam logic [1:0] S_UNSEEDED = 2'd0;
    localparam logic [1:0] S_LOAD     = 2'd1;
    localparam logic [1:0] S_WARMUP   = 2'd2;
    localparam logic [1:0] S_RUN      = 2'd3;

    logic [1:0]       state;
    logic [IDX_W-1:0] load_idx;
    logic [7:0]       warm_cnt;
    logic [31:0]      lfsr_q   [NUM_LFSR];
    logic [31:0]      lfsr_adv [NUM_LFSR];
    logic [NUM_LFSR*32-1:0] flat;
    logic [31:0]      seed_word;
    logic             seed_fire;
    logic             unused_bits;

    // One advance is 32 unrolled steps so every output word is entirely fresh.
    function automatic logic [31:0] lfsr_advance(input logic [31:0] s);
        logic [31:0] v;
        v = s;
        for (int i = 0; i < 32; i++) begin
            v = {v[30:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
        end
        return v;
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_LFSR; i++) begin
            lfsr_adv[i] = lfsr_advance(lfsr_q[i]);
        end
    end

    always_comb begin
        flat = '0;
        for (int i = 0; i < NUM_LFSR; i++) begin
            flat[i*32 +: 32] = lfsr_q[i];
        end
    end

    // An all-zero state would lock the LFSR, so a zero seed is stored as 1.
    assign seed_word = (in_seed == 32'h0) ? 32'h1 : in_seed;

    // Seeds are accepted in every state, including reseeding while running.
    assign out_seed_ready = 1'b1;
    assign seed_fire      = in_seed_valid && out_seed_ready;

    assign out_valid   = (state == S_RUN);
    assign out_r_raw   = flat[R_BITS-1:0];
    assign out_p       = flat[OUT_BITS-1:R_BITS];
    assign unused_bits = ^flat;

    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            state    <= S_UNSEEDED;
            load_idx <= '0;
            warm_cnt <= '0;
            for (int i = 0; i < NUM_LFSR; i++) begin
                lfsr_q[i] <= 32'h1;
            end
        end else begin
            case (state)
                S_UNSEEDED: begin
                    if (seed_fire) begin
                        lfsr_q[0] <= seed_word;
                        load_idx  <= IDX_W'(1);
                        warm_cnt  <= '0;
                        state     <= (NUM_LFSR == 1) ? S_WARMUP : S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (seed_fire) begin
                        for (int i = 0; i < NUM_LFSR; i++) begin
                            if (load_idx == IDX_W'(i)) begin
                                lfsr_q[i] <= seed_word;
                            end
                        end
                        load_idx <= load_idx + IDX_W'(1);
                        if (load_idx == IDX_W'(NUM_LFSR - 1)) begin
                            warm_cnt <= '0;
                            state    <= S_WARMUP;
                        end
                    end
                end
                S_WARMUP: begin
                    for (int i = 0; i < NUM_LFSR; i++) begin
                        lfsr_q[i] <= lfsr_adv[i];
                    end
                    warm_cnt <= warm_cnt + 8'd1;
                    if (warm_cnt == 8'(WARMUP_CYCLES - 1)) begin
                        state <= S_RUN;
                    end
                    if (seed_fire) begin
                        lfsr_q[0] <= seed_word;
                        load_idx  <= IDX_W'(1);
                        warm_cnt  <= '0;
                        state     <= (NUM_LFSR == 1) ? S_WARMUP : S_LOAD;
                    end
                end
                S_RUN: begin
                    if (in_ready) begin
                        for (int i = 0; i < NUM_LFSR; i++) begin
                            lfsr_q[i] <= lfsr_adv[i];
                        end
                    end
                    // A reseed overrides only LFSR[0]; a concurrent consume still completes.
                    if (seed_fire) begin
                        lfsr_q[0] <= seed_word;
                        load_idx  <= IDX_W'(1);
                        warm_cnt  <= '0;
                        state     <= (NUM_LFSR == 1) ? S_WARMUP : S_LOAD;
                    end
                end
                default: begin
                    state <= S_UNSEEDED;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_masked_random_feeder.sv
// Bench for masked_random_feeder: a one-LFSR instance driven from a vector table and a
// three-LFSR instance loaded with gapped seeds, both checked against a reference LFSR.

module tb_masked_random_feeder;

    localparam int WARM = 16;

    logic        clk;
    logic        rst;

    logic [31:0] seed_a;
    logic        seed_valid_a;
    logic        seed_ready_a;
    logic [3:0]  r_raw_a;
    logic [3:0]  p_a;
    logic        valid_a;
    logic        ready_a;

    logic [31:0] seed_b;
    logic        seed_valid_b;
    logic        seed_ready_b;
    logic [47:0] r_raw_b;
    logic [47:0] p_b;
    logic        valid_b;
    logic        ready_b;

    int vectors;
    int miscompares;

    logic [7:0]  exp_a_q[$];
    logic [95:0] exp_b_q[$];
    logic [31:0] model_a;
    logic [31:0] model_b [3];

    typedef struct {
        logic [31:0] seed;
        logic [7:0]  ready_pat;
        int          exp_adv;
        string       name;
    } vec_t;

    vec_t vecs[4];

    masked_random_feeder #(.NUM_SHARES(2), .BIT_WIDTH(4), .WARMUP_CYCLES(WARM)) dut_a (
        .in_clock       (clk),
        .in_reset       (rst),
        .in_seed        (seed_a),
        .in_seed_valid  (seed_valid_a),
        .out_seed_ready (seed_ready_a),
        .out_r_raw      (r_raw_a),
        .out_p          (p_a),
        .out_valid      (valid_a),
        .in_ready       (ready_a)
    );

    masked_random_feeder #(.NUM_SHARES(4), .BIT_WIDTH(8), .WARMUP_CYCLES(WARM)) dut_b (
        .in_clock       (clk),
        .in_reset       (rst),
        .in_seed        (seed_b),
        .in_seed_valid  (seed_valid_b),
        .out_seed_ready (seed_ready_b),
        .out_r_raw      (r_raw_b),
        .out_p          (p_b),
        .out_valid      (valid_b),
        .in_ready       (ready_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference advance: feedback is the parity of taps 32,22,2,1 of the polynomial.
    function automatic logic [31:0] m_adv(input logic [31:0] s);
        logic [31:0] v;
        v = s;
        for (int i = 0; i < 32; i++) begin
            v = (v << 1) | {31'b0, ^(v & 32'h8020_0003)};
        end
        return v;
    endfunction

    function automatic logic [31:0] m_seeded(input logic [31:0] s, input int n);
        logic [31:0] v;
        v = (s == 32'h0) ? 32'h1 : s;
        for (int i = 0; i < n; i++) begin
            v = m_adv(v);
        end
        return v;
    endfunction

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst          = 1'b1;
        seed_valid_a = 1'b0;
        seed_valid_b = 1'b0;
        ready_a      = 1'b0;
        ready_b      = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Count edges after the seed-accepting edge until out_valid appears (bounded).
    task automatic wait_valid_a(input string name);
        int cnt;
        cnt = 0;
        while (!valid_a && cnt < 100) begin
            @(posedge clk);
            @(negedge clk);
            cnt++;
        end
        check(name, 96'(cnt), 96'(WARM));
    endtask

    task automatic seed_a_and_wait(input logic [31:0] s);
        seed_a       = s;
        seed_valid_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        seed_valid_a = 1'b0;
        check("a_valid_after_seed", 96'(valid_a), 96'(0));
        wait_valid_a("a_latency");
        exp_a_q.delete();
        model_a = m_seeded(s, WARM);
        exp_a_q.push_back(model_a[7:0]);
    endtask

    task automatic run_a(input logic [7:0] pat);
        for (int i = 0; i < 8; i++) begin
            check("a_run_valid", 96'(valid_a), 96'(1));
            if (exp_a_q.size() == 0) begin
                check("a_queue_empty", 96'(0), 96'(1));
            end else begin
                check("a_run_vector", 96'({p_a, r_raw_a}), 96'(exp_a_q[0]));
            end
            ready_a = pat[i];
            @(posedge clk);
            if (pat[i]) begin
                void'(exp_a_q.pop_front());
                model_a = m_adv(model_a);
                exp_a_q.push_back(model_a[7:0]);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        rst          = 1'b1;
        seed_a       = 32'h0;
        seed_valid_a = 1'b0;
        ready_a      = 1'b0;
        seed_b       = 32'h0;
        seed_valid_b = 1'b0;
        ready_b      = 1'b0;

        vecs[0] = '{seed: 32'hDEADBEEF, ready_pat: 8'hFF,        exp_adv: 8, name: "deadbeef"};
        vecs[1] = '{seed: 32'h00000000, ready_pat: 8'hFF,        exp_adv: 8, name: "zero_guard"};
        vecs[2] = '{seed: 32'h00000001, ready_pat: 8'hFF,        exp_adv: 8, name: "one"};
        vecs[3] = '{seed: 32'hDEADBEEF, ready_pat: 8'b0000_1001, exp_adv: 2, name: "ready_toggle"};

        do_reset();
        check("rst_valid_a",      96'(valid_a),       96'(0));
        check("rst_seed_ready_a", 96'(seed_ready_a),  96'(1));
        check("rst_vector_a",     96'({p_a, r_raw_a}), 96'(8'h01));
        check("rst_valid_b",      96'(valid_b),       96'(0));
        check("rst_vector_b",     {p_b, r_raw_b},     {32'h1, 32'h1, 32'h1});

        for (int k = 0; k < 4; k++) begin
            do_reset();
            seed_a_and_wait(vecs[k].seed);
            run_a(vecs[k].ready_pat);
            check({vecs[k].name, "_final"}, 96'({p_a, r_raw_a}),
                  96'(m_seeded(vecs[k].seed, WARM + vecs[k].exp_adv) & 32'hFF));
            ready_a = 1'b0;
        end

        // Reseed while running with a concurrent consume.
        do_reset();
        seed_a_and_wait(32'hDEADBEEF);
        run_a(8'hFF);
        ready_a = 1'b1;
        seed_a_and_wait(32'h12345678);
        run_a(8'hFF);
        check("reseed_final", 96'({p_a, r_raw_a}), 96'(m_seeded(32'h12345678, WARM + 8) & 32'hFF));
        ready_a = 1'b0;

        // Reset in the middle of warmup, then replay.
        do_reset();
        seed_a       = 32'hDEADBEEF;
        seed_valid_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        seed_valid_a = 1'b0;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("warm_rst_valid",      96'(valid_a),        96'(0));
        check("warm_rst_seed_ready", 96'(seed_ready_a),   96'(1));
        check("warm_rst_vector",     96'({p_a, r_raw_a}), 96'(8'h01));
        seed_a_and_wait(32'hDEADBEEF);
        run_a(8'hFF);
        ready_a = 1'b0;

        // Three-LFSR instance: seeds 1,2,3 with random gaps in seed_valid.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            int gap;
            gap = int'($urandom_range(1, 4));
            for (int g = 0; g < gap; g++) begin
                @(posedge clk);
                @(negedge clk);
                check("b_load_gap_valid", 96'(valid_b),      96'(0));
                check("b_load_gap_ready", 96'(seed_ready_b), 96'(1));
            end
            seed_b       = 32'(k + 1);
            seed_valid_b = 1'b1;
            @(posedge clk);
            @(negedge clk);
            seed_valid_b = 1'b0;
            check("b_valid_after_seed", 96'(valid_b), 96'(0));
        end
        begin
            int cnt;
            cnt = 0;
            while (!valid_b && cnt < 100) begin
                @(posedge clk);
                @(negedge clk);
                cnt++;
            end
            check("b_latency", 96'(cnt), 96'(WARM));
        end
        for (int i = 0; i < 3; i++) begin
            model_b[i] = m_seeded(32'(i + 1), WARM);
        end
        exp_b_q.delete();
        exp_b_q.push_back({model_b[2], model_b[1], model_b[0]});
        for (int i = 0; i < 6; i++) begin
            check("b_run_valid",  96'(valid_b),  96'(1));
            check("b_run_vector", {p_b, r_raw_b}, exp_b_q[0]);
            ready_b = 1'b1;
            @(posedge clk);
            void'(exp_b_q.pop_front());
            for (int j = 0; j < 3; j++) begin
                model_b[j] = m_adv(model_b[j]);
            end
            exp_b_q.push_back({model_b[2], model_b[1], model_b[0]});
            @(negedge clk);
        end
        ready_b = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
